// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg: shared output-stage state encoding for the commit controller
package commit_ctrl_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_e;
endpackage

// File: rtl/commit_ctrl_done_table.sv
// done_table: per-tag completion bitmap with set, clear, clear-all and bypassed read
module done_table #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             set_en,
  input  logic [WIDTH-1:0] set_tag,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_tag,
  input  logic             clr_all,
  input  logic [WIDTH-1:0] rd_tag,
  output logic             rd_done
);
  localparam int N = 2 ** WIDTH;
  logic [N-1:0] done_q, done_d, set_m, clr_m;
  // clear wins over a same-edge set so a popped tag never lingers as done
  always_comb begin
    set_m   = set_en ? N'(1) << set_tag : '0;
    clr_m   = clr_en ? N'(1) << clr_tag : '0;
    done_d  = clr_all ? '0 : (done_q | set_m) & ~clr_m;
    rd_done = done_q[rd_tag] | (set_en & (set_tag == rd_tag));
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) done_q <= '0;
    else done_q <= done_d;
  end
endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl: retires completed tags in ring-buffer order through a one-entry output register
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_empty,
  output logic             o_re,
  input  logic             i_wb_en,
  input  logic [WIDTH-1:0] i_wb_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_tag,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_cnt
);
  ostate_e          state_q, state_d;
  logic [WIDTH-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             head_done, hs;
  done_table #(.WIDTH(WIDTH)) u_done (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .set_en  (i_wb_en),
    .set_tag (i_wb_tag),
    .clr_en  (o_re),
    .clr_tag (i_data),
    .clr_all (i_flush),
    .rd_tag  (i_data),
    .rd_done (head_done)
  );
  // gating on i_rst keeps the ring buffer from losing a tag while we reset
  always_comb begin
    hs      = (state_q == FULL) && i_ready;
    o_re    = !i_rst && !i_empty && head_done && ((state_q == EMPTY) || i_ready) && !i_flush;
    o_valid = state_q == FULL;
    o_tag   = tag_q;
    o_cnt   = cnt_q;
  end
  always_comb begin
    state_d = i_flush ? EMPTY : o_re ? FULL : hs ? EMPTY : state_q;
    tag_d   = o_re ? i_data : tag_q;
    cnt_d   = cnt_q + CNT_W'(hs && !i_flush);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed stimulus, per-cycle reference model plus literal spot checks
module tb_commit_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  logic             i_clk = 0;
  logic             i_rst, i_empty, i_wb_en, i_ready, i_flush;
  logic [WIDTH-1:0] i_data, i_wb_tag;
  logic             o_re, o_valid;
  logic [WIDTH-1:0] o_tag;
  logic [CNT_W-1:0] o_cnt;
  int checks = 0;
  int errors = 0;
  commit_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_empty(i_empty), .o_re(o_re),
    .i_wb_en(i_wb_en), .i_wb_tag(i_wb_tag), .o_valid(o_valid), .o_tag(o_tag),
    .i_ready(i_ready), .i_flush(i_flush), .o_cnt(o_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // reference model: set of done tags, optional retired tag waiting downstream, accepted count
  bit               m_done [2**WIDTH];
  bit               m_valid;
  logic [WIDTH-1:0] m_tag;
  int               m_cnt;
  bit               started = 0;
  always @(negedge i_clk) begin
    bit done_now, pop;
    if (i_rst) begin
      chk("model_re_in_reset", o_re, 0);
      foreach (m_done[k]) m_done[k] = 0;
      m_valid = 0; m_tag = '0; m_cnt = 0; started = 1;
    end else if (started) begin
      chk("model_valid", o_valid, m_valid);
      chk("model_tag", o_tag, m_tag);
      chk("model_cnt", o_cnt, m_cnt % (2 ** CNT_W));
      done_now = m_done[i_data] || (i_wb_en && i_wb_tag == i_data);
      pop = !i_empty && done_now && (!m_valid || i_ready) && !i_flush;
      chk("model_re", o_re, pop);
      if (i_flush) begin
        foreach (m_done[k]) m_done[k] = 0;
        m_valid = 0;
      end else begin
        if (m_valid && i_ready) m_cnt++;
        if (i_wb_en) m_done[i_wb_tag] = 1;
        if (pop) begin
          m_done[i_data] = 0;
          m_valid = 1;
          m_tag = i_data;
        end else if (m_valid && i_ready) m_valid = 0;
      end
    end
  end
  task automatic settle(); @(negedge i_clk); endtask
  task automatic adv(); @(posedge i_clk); #1; endtask
  task automatic idle();
    i_empty = 1; i_wb_en = 0; i_flush = 0;
  endtask
  task automatic do_reset();
    i_rst = 1; adv(); i_rst = 0; idle(); i_ready = 0;
  endtask
  task automatic wb(input logic [WIDTH-1:0] t);
    i_wb_en = 1; i_wb_tag = t; adv(); i_wb_en = 0;
  endtask
  initial begin
    i_rst = 1; i_empty = 1; i_data = '0; i_wb_en = 0; i_wb_tag = '0; i_ready = 0; i_flush = 0;
    adv(); adv();
    i_rst = 0;
    settle();
    chk("reset_valid", o_valid, 0);
    chk("reset_tag", o_tag, 0);
    chk("reset_cnt", o_cnt, 0);
    // head 3 never completes: nothing retires
    i_empty = 0; i_data = 3; i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("nodone_re", o_re, 0); chk("nodone_valid", o_valid, 0); adv();
    end
    // bypassed completion of the head pops it immediately
    i_wb_en = 1; i_wb_tag = 3;
    settle(); chk("byp_re", o_re, 1); adv();
    idle();
    settle(); chk("byp_valid", o_valid, 1); chk("byp_tag", o_tag, 3); chk("byp_cnt0", o_cnt, 0); adv();
    i_empty = 0; i_data = 3;
    settle(); chk("byp_cnt1", o_cnt, 1); chk("byp_cleared_re", o_re, 0); adv();
    // back-pressure then back-to-back retirement
    do_reset();
    wb(1); wb(2); wb(3);
    i_empty = 0; i_data = 1; i_ready = 0;
    settle(); chk("bp_pop1", o_re, 1); adv();
    i_data = 2;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("bp_stall_re", o_re, 0); chk("bp_hold_tag", o_tag, 1); adv();
    end
    i_ready = 1;
    settle(); chk("bp_pop2", o_re, 1); adv();
    i_data = 3;
    settle(); chk("bp_pop3", o_re, 1); chk("bp_tag2", o_tag, 2); adv();
    idle();
    settle(); chk("bp_tag3", o_tag, 3); adv();
    settle(); chk("bp_cnt", o_cnt, 3); chk("bp_empty", o_valid, 0);
    adv();
    // writeback to another tag on a pop edge
    do_reset();
    wb(5);
    i_empty = 0; i_data = 5; i_ready = 1; i_wb_en = 1; i_wb_tag = 7;
    settle(); chk("oth_pop5", o_re, 1); adv();
    i_wb_en = 0;
    settle(); chk("oth_done5_clr", o_re, 0); adv();
    i_data = 7;
    settle(); chk("oth_done7_set", o_re, 1); adv();
    // flush overrides pop, handshake and writeback
    do_reset();
    wb(6);
    i_empty = 0; i_data = 4; i_wb_en = 1; i_wb_tag = 4; i_ready = 0;
    adv();
    i_wb_en = 0; i_data = 6;
    settle(); chk("fl_tag4", o_tag, 4); chk("fl_cnt_before", o_cnt, 0);
    adv();
    i_flush = 1; i_ready = 1; i_wb_en = 1; i_wb_tag = 9;
    settle(); chk("fl_re", o_re, 0); adv();
    i_flush = 0; i_wb_en = 0;
    settle(); chk("fl_valid", o_valid, 0); chk("fl_cnt", o_cnt, 0); chk("fl_map6", o_re, 0); adv();
    i_data = 9;
    settle(); chk("fl_map9", o_re, 0); adv();
    // counter wrap with a 4-bit counter, then reset mid-stream
    do_reset();
    i_ready = 1; i_empty = 0; i_wb_en = 1;
    for (int i = 0; i < 17; i++) begin
      i_data = WIDTH'(i); i_wb_tag = WIDTH'(i); adv();
    end
    idle(); adv();
    settle(); chk("wrap_cnt", o_cnt, 1); adv();
    i_empty = 0; i_wb_en = 1; i_data = 2; i_wb_tag = 2; adv();
    i_rst = 1; i_data = 3; i_wb_tag = 3;
    settle(); chk("rst_re", o_re, 0); adv();
    i_rst = 0; idle();
    settle(); chk("rst_valid", o_valid, 0); chk("rst_tag", o_tag, 0); chk("rst_cnt", o_cnt, 0);
    adv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
